// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: sequential PC+4 or word-aligned branch/jump target.
// With FETCH_MISALIGN_TRAP_EN a misaligned taken target is flagged and passed through.
module pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    logic [XLEN-1:0] target_aligned;

    assign pc_plus4       = pc + XLEN'(4);
    assign target_aligned = pc_target & ~XLEN'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = pc_src && (pc_target[1:0] != 2'b00);

    // The trapping PC keeps the raw target so the handler sees the bad address.
    always_comb begin
        next_pc = pc_plus4;
        if (misalign)
            next_pc = pc_target;
        else if (pc_src)
            next_pc = target_aligned;
    end
`else
    assign next_pc = pc_src ? target_aligned : pc_plus4;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request, Instr hold.
// FETCH_MISALIGN_TRAP_EN adds a sticky misalign_trap output and HALT state.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            InstrValid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap
`endif
);

    fetch_state_e    state, state_next;
    logic            latch, consume;
    logic [XLEN-1:0] next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign;
`endif

    pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc        (PC),
        .pc_src    (PCSrc),
        .pc_target (PCTarget),
        .pc_plus4  (PCPlus4),
        .next_pc   (next_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    // Request is suppressed in the reset cycle so memory never sees a stale one.
    assign imem_req  = ((state == REQ) || (state == WAIT)) && !reset;
    assign imem_addr = PC;

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        consume    = 1'b0;
        unique case (state)
            REQ: begin
                if (imem_rvalid) begin
                    latch      = 1'b1;
                    state_next = HOLD;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    latch      = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (InstrValid && !stall) begin
                    consume    = 1'b1;
                    state_next = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (misalign)
                        state_next = HALT;
`endif
                end
            end
            HALT: begin
                state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQ;
            PC         <= RESET_PC;
            Instr      <= NOP_INSTR;
            InstrValid <= 1'b0;
        end else begin
            state <= state_next;
            if (latch) begin
                Instr      <= imem_rdata;
                InstrValid <= 1'b1;
            end
            if (consume) begin
                PC         <= next_pc;
                InstrValid <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)
            misalign_trap <= 1'b0;
        else if (consume && misalign)
            misalign_trap <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit, plus stall/wait/reset/misalign sequences.
// Build with FETCH_MISALIGN_TRAP_EN to exercise the trap path.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrValid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .InstrValid  (InstrValid)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        src;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hold_pc;

        vecs[0] = '{32'h0050_0093, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{32'h0010_0113, 1'b1, 32'h0000_0100, 32'h0000_0004, 32'h0000_0100};
        vecs[2] = '{32'h0020_0193, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0000_0104};
        vecs[3] = '{32'h0030_0213, 1'b1, 32'hFFFF_FFFC, 32'h0000_0104, 32'hFFFF_FFFC};
        vecs[4] = '{32'h0040_0293, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[5] = '{32'h0060_0313, 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};

        reset = 1'b1; stall = 1'b0; PCSrc = 1'b0; PCTarget = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_valid", {31'b0, InstrValid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
`endif
        reset = 1'b0;
        #1;

        // Zero-wait fetch, then consume with the vector's PCSrc/PCTarget.
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'h1);
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_pc);
            imem_rvalid = 1'b1;
            imem_rdata  = vecs[i].rdata;
            tick();
            imem_rvalid = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'b0, InstrValid}, 32'h1);
            chk($sformatf("v%0d_instr", i), Instr, vecs[i].rdata);
            chk($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
            chk($sformatf("v%0d_pc4", i), PCPlus4, vecs[i].exp_pc + 32'd4);
            chk($sformatf("v%0d_hreq", i), {31'b0, imem_req}, 32'h0);
            PCSrc    = vecs[i].src;
            PCTarget = vecs[i].target;
            tick();
            PCSrc = 1'b0;
            chk($sformatf("v%0d_next", i), imem_addr, vecs[i].exp_next);
            chk($sformatf("v%0d_cleared", i), {31'b0, InstrValid}, 32'h0);
        end

        // Delayed response: request and address held across 4 cycles.
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("wait%0d_req", c), {31'b0, imem_req}, 32'h1);
            chk($sformatf("wait%0d_addr", c), imem_addr, 32'h8000_0000);
            if (c < 3) tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0513;
        tick();
        chk("wait_instr", Instr, 32'h00A0_0513);
        chk("wait_valid", {31'b0, InstrValid}, 32'h1);

        // Stall with a spurious response that must be ignored.
        stall      = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        hold_pc    = 32'h8000_0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            imem_rvalid = 1'b0;
            chk($sformatf("stall%0d_instr", c), Instr, 32'h00A0_0513);
            chk($sformatf("stall%0d_pc", c), PC, hold_pc);
            chk($sformatf("stall%0d_req", c), {31'b0, imem_req}, 32'h0);
            chk($sformatf("stall%0d_valid", c), {31'b0, InstrValid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        chk("release_addr", imem_addr, 32'h8000_0004);
        chk("release_req", {31'b0, imem_req}, 32'h1);
        tick();
        chk("release_once", imem_addr, 32'h8000_0004);
        chk("release_wait_req", {31'b0, imem_req}, 32'h1);

        // Reset while waiting, with a response in the reset cycle.
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("rstw_addr", imem_addr, 32'h0);
        chk("rstw_valid", {31'b0, InstrValid}, 32'h0);
        chk("rstw_instr", Instr, 32'h0000_0013);
        chk("rstw_req", {31'b0, imem_req}, 32'h1);

        // Misaligned taken target.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_006F;
        tick();
        imem_rvalid = 1'b0;
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0102;
        tick();
        PCSrc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("trap%0d_flag", c), {31'b0, misalign_trap}, 32'h1);
            chk($sformatf("trap%0d_req", c), {31'b0, imem_req}, 32'h0);
            chk($sformatf("trap%0d_valid", c), {31'b0, InstrValid}, 32'h0);
            imem_rvalid = 1'b1;
            tick();
            imem_rvalid = 1'b0;
        end
        chk("trap_pc", PC, 32'h0000_0102);
`else
        chk("mis_addr", imem_addr, 32'h0000_0100);
        chk("mis_req", {31'b0, imem_req}, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
